// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets REQ_NUM requesters share one FIFO write port.
// Define FIFO_ARB_BURST_EN to keep a grant for up to BURST_LEN beats; otherwise every grant is one beat.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int REQ_NUM    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [REQ_NUM-1:0]            req,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
    output logic [REQ_NUM-1:0]            ack,
    output logic [REQ_NUM-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          busy
);

    localparam int IDX_W = $clog2(REQ_NUM);

    if (REQ_NUM < 2 || REQ_NUM > 8) begin : g_bad_req_num
        $error("fifo_wr_arbiter: REQ_NUM must be 2..8");
    end
    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("fifo_wr_arbiter: BURST_LEN must be 1..16");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [REQ_NUM-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;

    logic [IDX_W-1:0]      gidx;
    logic                  beat;
    logic                  last_beat;
    logic [REQ_NUM-1:0]    pick_oh;
    logic                  pick_valid;
    logic [DATA_WIDTH-1:0] data_sel;

    // Index of the current owner; zero when nothing is granted.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant_q[i]) begin
                gidx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        beat = (state_q == GRANT) && req[gidx] && !fifo_full;
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        logic [IDX_W-1:0] idx;
        pick_oh    = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int off = 1; off <= REQ_NUM; off++) begin
            idx = IDX_W'((int'(last_owner_q) + off) % REQ_NUM);
            if (!pick_valid && req[idx]) begin
                pick_oh[idx] = 1'b1;
                pick_valid   = 1'b1;
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (grant_q[i]) begin
                data_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    logic [3:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        last_beat = beat && (beat_cnt_q == 4'(BURST_LEN - 1));
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == GRANT && state_d == IDLE) begin
            beat_cnt_d = '0;
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    always_comb begin
        last_beat = beat;
    end
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    grant_d = pick_oh;
                end
            end
            GRANT: begin
                // A dropped request or the final beat of a burst hands the port back.
                if (!req[gidx] || last_beat) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_owner_d = gidx;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_owner_q <= IDX_W'(REQ_NUM - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        ack        = beat ? grant_q : '0;
        fifo_wr_en = beat;
        fifo_data  = data_sel;
        grant      = grant_q;
        busy       = (state_q == GRANT);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter: a transaction-level owner model
// predicts grants and FIFO writes; a monitor compares them against the DUT each cycle.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int RN = 4;
    localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam int EFF_BURST = BL;
`else
    localparam int EFF_BURST = 1;
`endif
    localparam int DEPTH = 64;

    logic              wr_clk = 1'b0;
    logic              wr_rst_n = 1'b0;
    logic [RN-1:0]     req = '0;
    logic [RN*DW-1:0]  req_data = '0;
    logic              fifo_full = 1'b0;
    logic [RN-1:0]     ack;
    logic [RN-1:0]     grant;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data;
    logic              busy;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .REQ_NUM(RN), .BURST_LEN(BL)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .req(req), .req_data(req_data),
        .ack(ack), .grant(grant), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data(fifo_data), .busy(busy)
    );

    // clock / reset
    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int errors = 0;

    logic [RN+DW-1:0] exp_q[$];
    logic [RN-1:0]    exp_grant_q[$];

    logic [DW-1:0] src_data [RN][DEPTH];
    int            head [RN];
    int            len  [RN];
    logic [RN-1:0] ack_s = '0;
    int            full_pct = 0;
    int            drop_pct = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, who owned it last, beats in this grant.
    int m_owner = -1;
    int m_last  = RN - 1;
    int m_beats = 0;
    initial begin
        logic [RN-1:0] g;
        bit            b;
        bit            found;
        int            c;
        forever begin
            @(negedge wr_clk);
            if (!wr_rst_n) begin
                m_owner = -1;
                m_last  = RN - 1;
                m_beats = 0;
            end else begin
                g = '0;
                if (m_owner >= 0) g[m_owner] = 1'b1;
                exp_grant_q.push_back(g);
                if (m_owner >= 0) begin
                    b = req[m_owner] && !fifo_full;
                    if (b) begin
                        exp_q.push_back({g, req_data[m_owner*DW +: DW]});
                        m_beats++;
                    end
                    if (!req[m_owner] || (b && m_beats == EFF_BURST)) begin
                        m_last  = m_owner;
                        m_owner = -1;
                        m_beats = 0;
                    end
                end else if (req != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= RN; k++) begin
                        c = (m_last + k) % RN;
                        if (!found && req[c]) begin
                            m_owner = c;
                            found   = 1'b1;
                        end
                    end
                    m_beats = 0;
                end
            end
        end
    end

    // Monitor: pops the model's expectations and compares.
    initial begin
        logic [RN+DW-1:0] e;
        logic [RN-1:0]    eg;
        forever begin
            @(negedge wr_clk);
            #1;
            ack_s = ack;
            if (!wr_rst_n) begin
                chk("reset_outputs", {ack, grant, fifo_wr_en, fifo_data, busy}, '0);
            end else begin
                if (exp_grant_q.size() == 0) begin
                    chk("grant_q_empty", 1, 0);
                end else begin
                    eg = exp_grant_q.pop_front();
                    chk("grant", grant, eg);
                    chk("busy", busy, eg != '0);
                end
                if (fifo_wr_en) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {ack, fifo_data}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_ack_data", {ack, fifo_data}, e);
                    end
                end else begin
                    chk("idle_ack", ack, 0);
                end
                if (grant == '0) chk("data_zero_no_grant", fifo_data, 0);
            end
        end
    end

    // driver tasks
    task automatic add_items(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            if (len[i] < DEPTH) begin
                src_data[i][len[i]] = DW'($urandom);
                len[i]++;
            end
        end
    endtask

    task automatic step(input logic rst_val);
        bit en;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < RN; i++) begin
            if (ack_s[i]) head[i]++;
            en = ($urandom_range(0, 99) >= drop_pct);
            req[i] = en && (head[i] < len[i]);
            req_data[i*DW +: DW] = (head[i] < len[i]) ? src_data[i][head[i]] : '0;
        end
        fifo_full = ($urandom_range(0, 99) < full_pct);
        wr_rst_n  = rst_val;
    endtask

    task automatic drain();
        int budget;
        full_pct = 0;
        drop_pct = 0;
        budget   = 0;
        while (budget < 600 &&
               !(head[0] == len[0] && head[1] == len[1] && head[2] == len[2] && head[3] == len[3])) begin
            step(1'b1);
            budget++;
        end
        chk("drain_in_budget", budget < 600, 1);
        repeat (4) step(1'b1);
    endtask

    initial begin
        int budget;
        for (int i = 0; i < RN; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end
        #1;
        chk("reset_at_start", {ack, grant, fifo_wr_en, fifo_data, busy}, '0);
        repeat (3) step(1'b0);
        step(1'b1);

        // All requesters busy with no back-pressure: strict round-robin.
        for (int i = 0; i < RN; i++) add_items(i, 6);
        drain();

        // Random back-pressure and request drops.
        full_pct = 25;
        drop_pct = 15;
        for (int r = 0; r < 8; r++) begin
            add_items($urandom_range(0, RN - 1), $urandom_range(1, 8));
            add_items($urandom_range(0, RN - 1), $urandom_range(1, 8));
            repeat (40) step(1'b1);
        end
        drain();

        // Reset in the middle of traffic from requesters 0 and 3.
        add_items(0, 6);
        add_items(3, 6);
        budget = 0;
        do begin
            step(1'b1);
            budget++;
        end while (!fifo_wr_en && budget < 20);
        chk("first_write_seen", fifo_wr_en, 1);
        step(1'b1);
        step(1'b0);
        #1;
        chk("reset_immediate", {ack, grant, fifo_wr_en, fifo_data, busy}, '0);
        step(1'b0);
        step(1'b1);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each requester's data and of the FIFO write data.
REQ-002 The block SHALL have parameter REQ_NUM, default 4 (legal 2..8), giving the number of requesters.
REQ-003 The block SHALL have parameter BURST_LEN, default 4 (legal 1..16), giving the maximum beats per grant when ARB_BURST_EN is defined.
REQ-004 Port wr_clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port wr_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port req, input, REQ_NUM: per-requester write request; bit i is requester i.
REQ-007 Port req_data, input, REQ_NUM*DATA_WIDTH: requester i's data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port ack, output, REQ_NUM: one-hot beat-accepted strobe.
REQ-009 Port grant, output, REQ_NUM: registered one-hot current owner, or all-zero.
REQ-010 Port fifo_full, input, 1: full flag of the downstream FIFO write side.
REQ-011 Port fifo_wr_en, output, 1: FIFO write enable.
REQ-012 Port fifo_data, output, DATA_WIDTH: FIFO write data.
REQ-013 Port busy, output, 1: high while in GRANT state.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT.
REQ-015 In IDLE with any req bit high, the FSM SHALL select round-robin, starting the search at last_owner+1 modulo REQ_NUM, load the one-hot grant and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-016 In IDLE with req all-zero, the FSM SHALL hold IDLE with grant=0.
REQ-017 A beat SHALL occur in a GRANT cycle when req[g] is high and fifo_full is low, where g is the granted index.
REQ-018 On a beat, fifo_wr_en and ack[g] SHALL be high combinationally in the same cycle, and fifo_data SHALL equal requester g's slice.
REQ-019 With no beat, fifo_wr_en SHALL be 0 and ack SHALL be 0.
REQ-020 With grant=0, fifo_data SHALL be 0.
REQ-021 Requesters SHALL hold data stable while req is high and ack is low, and SHALL present the next beat's data the cycle after ack.
REQ-022 With fifo_full high in GRANT, the block SHALL hold the grant and beat count and issue no write.
REQ-023 A 4-bit beat counter SHALL increment per beat and clear on leaving GRANT.
REQ-024 GRANT SHALL be released (next state IDLE, grant=0, last_owner<=g) when req[g] is low in a cycle, or when a beat occurs with the beat counter at BURST_LEN-1.
REQ-025 A release and new requests in the same cycle SHALL arbitrate in the following IDLE cycle, giving exactly one bubble cycle between grants.
REQ-026 Requests from non-granted requesters SHALL never produce ack or a FIFO write.
REQ-027 A requester deasserting req before being granted SHALL lose its slot with no side effect.

Reset
REQ-028 Reset assertion SHALL immediately force state=IDLE, grant=0, beat counter=0, and last_owner=REQ_NUM-1, so requester 0 wins first.
REQ-029 During reset, ack, fifo_wr_en, fifo_data and busy SHALL be 0.
REQ-030 Reset mid-burst SHALL abort the burst; no partial beat is written after reset assertion.

Configuration
REQ-031 Macro FIFO_ARB_BURST_EN defined: the grant lasts up to BURST_LEN beats per REQ-024.
REQ-032 Macro FIFO_ARB_BURST_EN undefined: GRANT SHALL be released after every beat (effective BURST_LEN=1), BURST_LEN SHALL be ignored, and the beat counter SHALL not be built.

Verification
REQ-033 Reset, then req=4'b0001 held for 6 beats, FIFO not full, BURST_EN defined -> grant=0001 one cycle after req; beats 0x10..0x13 written on 4 consecutive cycles; 1 idle cycle; regrant; 0x14, 0x15 written.
REQ-034 req=4'b1111 continuous, BURST_LEN=1 -> grant order 0,1,2,3,0, with exactly one IDLE cycle between grants.
REQ-035 Granted requester 2, fifo_full high for 3 cycles mid-burst -> fifo_wr_en=0 and ack=0 for those 3 cycles; grant stays 0100; count resumes; 4 total beats written.
REQ-036 Requester 1 drops req after 2 beats -> release; last_owner=1; next grant goes to requester 2 if requesting.
REQ-037 wr_rst_n pulsed low during beat 2 of a burst -> outputs 0 immediately; after release, requester 0 wins first with req=4'b1001.
REQ-038 BURST_EN undefined, req=4'b0011 -> writes alternate 0,1,0,1; ack is never high on two consecutive grants to the same requester.
